uart_boot_loader: RTL and testbench

//  Consumes bytes from the uart receiver and runs a framed download protocol.

---
 rtl/uart_boot_loader_pkg.sv | 17 +
 rtl/uart_boot_loader_if.sv | 26 ++
 rtl/uart_boot_loader_word_packer.sv | 76 +++++++
 rtl/uart_boot_loader.sv | 142 ++++++++++++++
 tb/tb_uart_boot_loader.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_boot_loader_pkg.sv
// rtl/uart_boot_loader_pkg.sv - shared states and protocol bytes for the uart boot loader
package uart_boot_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      LEN,
      DATA,
      CSUM,
      RESPOND
   } boot_state_t;

   localparam logic [7:0] BOOT_MAGIC = 8'hB0;
   localparam logic [7:0] BOOT_ACK   = 8'h06;
   localparam logic [7:0] BOOT_NAK   = 8'h15;

endpackage

// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - word write bus from the boot loader to the memory arbiter
interface uart_boot_loader_if #(
   parameter int ADDR_W = 26
);
   logic              mem_request;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_byte_enable;
   logic              mem_ready;

   modport master (
      output mem_request,
      output mem_address,
      output mem_wdata,
      output mem_byte_enable,
      input  mem_ready
   );

   modport slave (
      input  mem_request,
      input  mem_address,
      input  mem_wdata,
      input  mem_byte_enable,
      output mem_ready
   );
endinterface

// File: rtl/uart_boot_loader_word_packer.sv
// rtl/uart_boot_loader_word_packer.sv - packs payload bytes into LE words behind a 1-entry write buffer
module uart_boot_loader_word_packer #(
   parameter int ADDR_W = 26
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_addr,
   input  logic [ADDR_W-1:2] load_value,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic              byte_last,
   input  logic              drop,
   output logic              overrun,
   uart_boot_loader_if.master mem
);

   logic [1:0]  lane;
   logic [31:0] acc;
   logic [3:0]  be_acc;
   logic [31:0] word_next;
   logic [3:0]  be_next;
   logic        commit;

   always_comb begin
      word_next = acc;
      word_next[{lane, 3'b000} +: 8] = byte_data;
      be_next = be_acc | (4'b0001 << lane);
      commit  = byte_valid && (lane == 2'd3 || byte_last);
      // A same-cycle accept frees the buffer, so only a still-blocked entry overruns
      overrun = commit && mem.mem_request && !mem.mem_ready;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lane                <= '0;
         acc                 <= '0;
         be_acc              <= '0;
         mem.mem_request     <= 1'b0;
         mem.mem_address     <= '0;
         mem.mem_wdata       <= '0;
         mem.mem_byte_enable <= '0;
      end else begin
         if (mem.mem_request && mem.mem_ready) begin
            mem.mem_request <= 1'b0;
            mem.mem_address <= mem.mem_address + ADDR_W'(4);
         end
         if (load_addr) begin
            mem.mem_address <= {load_value, 2'b00};
            lane            <= '0;
            acc             <= '0;
            be_acc          <= '0;
         end
         if (byte_valid) begin
            lane <= lane + 2'd1;
            if (commit) begin
               acc    <= '0;
               be_acc <= '0;
               if (!overrun) begin
                  mem.mem_request     <= 1'b1;
                  mem.mem_wdata       <= word_next;
                  mem.mem_byte_enable <= be_next;
               end
            end else begin
               acc    <= word_next;
               be_acc <= be_next;
            end
         end
         if (drop) begin
            mem.mem_request <= 1'b0;
            acc             <= '0;
            be_acc          <= '0;
         end
      end
   end

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - framed uart download into memory, holding the CPU in reset meanwhile
module uart_boot_loader
   import uart_boot_loader_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TIMEOUT_US = 10_000,
   parameter int ADDR_W     = 26
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_complete,
   input  logic [7:0] rx_data,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_complete,
   uart_boot_loader_if.master mem,
   output logic       cpu_reset_hold,
   output logic       busy,
   output logic       error
);

   localparam int TIMEOUT_CYCLES = (CLK_HZ / 1_000_000) * TIMEOUT_US;
   localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

   boot_state_t state;
   logic [1:0]  byte_cnt;
   logic [23:0] hdr_buf;
   logic [31:0] remaining;
   logic [7:0]  csum;
   logic [7:0]  csum_rx;
   logic        got_csum;
   logic        resp_ack;
   logic [TO_W-1:0] timer;

   logic [31:0] full_word;
   logic        pk_load;
   logic        pk_byte;
   logic        pk_overrun;
   logic        timed_out;
   logic        csum_have;
   logic [7:0]  csum_val;
   logic        respond_now;
   logic        respond_ack;

   always_comb begin
      full_word   = {rx_data, hdr_buf};
      pk_load     = (state == ADDR) && rx_complete && (byte_cnt == 2'd3);
      pk_byte     = (state == DATA) && rx_complete;
      timed_out   = (state inside {ADDR, LEN, DATA, CSUM}) && !rx_complete
                    && (timer == TO_W'(TIMEOUT_CYCLES - 1));
      csum_have   = got_csum || rx_complete;
      csum_val    = got_csum ? csum_rx : rx_data;
      respond_now = timed_out || pk_overrun
                    || ((state == CSUM) && csum_have && !mem.mem_request);
      respond_ack = !timed_out && !pk_overrun && (csum_val == csum);
   end

   uart_boot_loader_word_packer #(.ADDR_W(ADDR_W)) u_packer (
      .clock      (clock),
      .reset      (reset),
      .load_addr  (pk_load),
      .load_value (full_word[ADDR_W-1:2]),
      .byte_valid (pk_byte),
      .byte_data  (rx_data),
      .byte_last  (remaining == 32'd1),
      .drop       (timed_out || pk_overrun),
      .overrun    (pk_overrun),
      .mem        (mem)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         byte_cnt       <= '0;
         hdr_buf        <= '0;
         remaining      <= '0;
         csum           <= '0;
         csum_rx        <= '0;
         got_csum       <= 1'b0;
         resp_ack       <= 1'b0;
         timer          <= '0;
         tx_valid       <= 1'b0;
         tx_data        <= '0;
         cpu_reset_hold <= 1'b0;
         error          <= 1'b0;
      end else begin
         tx_valid <= 1'b0;
         if (rx_complete || state == IDLE || state == RESPOND) timer <= '0;
         else                                                  timer <= timer + TO_W'(1);

         if (respond_now) begin
            state    <= RESPOND;
            tx_valid <= 1'b1;
            tx_data  <= respond_ack ? BOOT_ACK : BOOT_NAK;
            resp_ack <= respond_ack;
            if (!respond_ack) error <= 1'b1;
         end else begin
            case (state)
               IDLE: if (rx_complete && rx_data == BOOT_MAGIC) begin
                  state          <= ADDR;
                  byte_cnt       <= '0;
                  csum           <= '0;
                  got_csum       <= 1'b0;
                  cpu_reset_hold <= 1'b1;
                  error          <= 1'b0;
               end
               ADDR: if (rx_complete) begin
                  hdr_buf  <= {rx_data, hdr_buf[23:8]};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) state <= LEN;
               end
               LEN: if (rx_complete) begin
                  hdr_buf  <= {rx_data, hdr_buf[23:8]};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     remaining <= full_word;
                     state     <= (full_word == 32'd0) ? CSUM : DATA;
                  end
               end
               DATA: if (rx_complete) begin
                  csum      <= csum + rx_data;
                  remaining <= remaining - 32'd1;
                  if (remaining == 32'd1) state <= CSUM;
               end
               // The checksum byte can arrive before the last word drains; keep it
               CSUM: if (rx_complete && !got_csum) begin
                  got_csum <= 1'b1;
                  csum_rx  <= rx_data;
               end
               RESPOND: if (tx_complete) begin
                  state <= IDLE;
                  if (resp_ack) cpu_reset_hold <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - directed self-checking bench for uart_boot_loader
module tb_uart_boot_loader;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       rx_complete = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_complete = 1'b0;
   logic       cpu_reset_hold;
   logic       busy;
   logic       error;

   uart_boot_loader_if #(.ADDR_W(26)) mem ();

   uart_boot_loader #(.CLK_HZ(1_000_000), .TIMEOUT_US(50), .ADDR_W(26)) dut (
      .clock          (clock),
      .reset          (reset),
      .rx_complete    (rx_complete),
      .rx_data        (rx_data),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .tx_complete    (tx_complete),
      .mem            (mem),
      .cpu_reset_hold (cpu_reset_hold),
      .busy           (busy),
      .error          (error)
   );

   always #5 clock = ~clock;

   int          total = 0;
   int          bad = 0;
   int          tx_count = 0;
   int          tx_cd = 0;
   logic [7:0]  last_tx = 8'h00;
   bit          auto_ready = 1'b0;
   logic [25:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [3:0]  wr_be[$];
   logic [7:0]  payload[$];

   initial mem.mem_ready = 1'b0;

   // memory arbiter model: accept when enabled, log each accepted word
   always @(negedge clock) begin
      mem.mem_ready = auto_ready && (mem.mem_request === 1'b1);
      if (mem.mem_ready) begin
         wr_addr.push_back(mem.mem_address);
         wr_data.push_back(mem.mem_wdata);
         wr_be.push_back(mem.mem_byte_enable);
      end
   end

   // transmitter model: completes each byte a few cycles after tx_valid
   always @(negedge clock) begin
      if (tx_cd > 0) begin
         tx_cd = tx_cd - 1;
         tx_complete = (tx_cd == 0);
      end else begin
         tx_complete = 1'b0;
      end
      if (tx_valid === 1'b1) begin
         tx_count++;
         last_tx = tx_data;
         tx_cd = 4;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      rx_data = b;
      rx_complete = 1'b1;
      @(negedge clock);
      rx_complete = 1'b0;
   endtask

   task automatic gap();
      @(negedge clock);
   endtask

   task automatic send_hdr(input logic [31:0] a, input logic [31:0] l);
      for (int i = 0; i < 4; i++) begin gap(); send_byte(a[i*8 +: 8]); end
      for (int i = 0; i < 4; i++) begin gap(); send_byte(l[i*8 +: 8]); end
   endtask

   task automatic send_payload();
      foreach (payload[i]) begin gap(); send_byte(payload[i]); end
   endtask

   task automatic clear_log();
      wr_addr.delete(); wr_data.delete(); wr_be.delete();
   endtask

   task automatic wait_response(input string name, input int prev);
      int n;
      n = 0;
      while (tx_count == prev && n < 400) begin @(negedge clock); n++; end
      total++;
      if (tx_count == prev) begin bad++; $display("FAIL %s_tx: pulses=%0d required>%0d", name, tx_count, prev); end
      n = 0;
      while (busy !== 1'b0 && n < 100) begin @(negedge clock); n++; end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle: busy=%b required 0", name, busy); end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      total++; if (cpu_reset_hold !== 1'b0) begin bad++; $display("FAIL reset_hold: got %b want 0", cpu_reset_hold); end
      total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
      total++; if (mem.mem_request !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem.mem_request); end
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_ack();
      int prev;
      prev = tx_count;
      clear_log();
      auto_ready = 1'b1;
      payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_byte(8'hB0);
      total++; if (cpu_reset_hold !== 1'b1) begin bad++; $display("FAIL ack_hold_on: got %b want 1", cpu_reset_hold); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ack_busy: got %b want 1", busy); end
      send_hdr(32'h0000_0100, 32'd8);
      send_payload();
      gap(); send_byte(8'h24);
      wait_response("ack", prev);
      total++; if (last_tx !== 8'h06) begin bad++; $display("FAIL ack_tx: got %h want 06", last_tx); end
      total++; if (cpu_reset_hold !== 1'b0) begin bad++; $display("FAIL ack_hold_off: got %b want 0", cpu_reset_hold); end
      total++; if (error !== 1'b0) begin bad++; $display("FAIL ack_error: got %b want 0", error); end
      total++;
      if (wr_addr.size() != 2) begin bad++; $display("FAIL ack_nwrites: got %0d want 2", wr_addr.size()); end
      else begin
         total++;
         if ({wr_addr[0], wr_data[0], wr_be[0]} !== {26'h100, 32'h04030201, 4'hF}) begin
            bad++; $display("FAIL ack_w0: got %h/%h/%h want 100/04030201/f", wr_addr[0], wr_data[0], wr_be[0]);
         end
         total++;
         if ({wr_addr[1], wr_data[1], wr_be[1]} !== {26'h104, 32'h08070605, 4'hF}) begin
            bad++; $display("FAIL ack_w1: got %h/%h/%h want 104/08070605/f", wr_addr[1], wr_data[1], wr_be[1]);
         end
      end
   endtask

   task automatic test_nak();
      int prev;
      prev = tx_count;
      clear_log();
      payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_byte(8'hB0);
      send_hdr(32'h0000_0100, 32'd8);
      send_payload();
      gap(); send_byte(8'h25);
      wait_response("nak", prev);
      total++; if (last_tx !== 8'h15) begin bad++; $display("FAIL nak_tx: got %h want 15", last_tx); end
      total++; if (error !== 1'b1) begin bad++; $display("FAIL nak_error: got %b want 1", error); end
      total++; if (cpu_reset_hold !== 1'b1) begin bad++; $display("FAIL nak_hold: got %b want 1", cpu_reset_hold); end
      total++; if (wr_addr.size() != 2) begin bad++; $display("FAIL nak_nwrites: got %0d want 2", wr_addr.size()); end
   endtask

   task automatic test_partial();
      int prev;
      prev = tx_count;
      clear_log();
      payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      send_byte(8'hB0);
      total++; if (error !== 1'b0) begin bad++; $display("FAIL part_error_clear: got %b want 0", error); end
      send_hdr(32'h0000_0200, 32'd6);
      send_payload();
      total++; if (mem.mem_request !== 1'b1) begin bad++; $display("FAIL part_latency: req=%b want 1", mem.mem_request); end
      gap(); send_byte(8'hFB);
      wait_response("part", prev);
      total++; if (last_tx !== 8'h06) begin bad++; $display("FAIL part_tx: got %h want 06", last_tx); end
      total++;
      if (wr_addr.size() != 2) begin bad++; $display("FAIL part_nwrites: got %0d want 2", wr_addr.size()); end
      else begin
         total++;
         if ({wr_addr[0], wr_data[0], wr_be[0]} !== {26'h200, 32'hDDCCBBAA, 4'hF}) begin
            bad++; $display("FAIL part_w0: got %h/%h/%h want 200/ddccbbaa/f", wr_addr[0], wr_data[0], wr_be[0]);
         end
         total++;
         if ({wr_addr[1], wr_data[1], wr_be[1]} !== {26'h204, 32'h0000FFEE, 4'h3}) begin
            bad++; $display("FAIL part_w1: got %h/%h/%h want 204/0000ffee/3", wr_addr[1], wr_data[1], wr_be[1]);
         end
      end
   endtask

   task automatic test_overrun();
      int prev;
      prev = tx_count;
      clear_log();
      auto_ready = 1'b0;
      payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_byte(8'hB0);
      send_hdr(32'h0000_0300, 32'd8);
      send_payload();
      total++; if (mem.mem_request !== 1'b0) begin bad++; $display("FAIL ovr_req_drop: got %b want 0", mem.mem_request); end
      wait_response("ovr", prev);
      total++; if (last_tx !== 8'h15) begin bad++; $display("FAIL ovr_tx: got %h want 15", last_tx); end
      total++; if (error !== 1'b1) begin bad++; $display("FAIL ovr_error: got %b want 1", error); end
      total++; if (wr_addr.size() != 0) begin bad++; $display("FAIL ovr_nwrites: got %0d want 0", wr_addr.size()); end
      auto_ready = 1'b1;
   endtask

   task automatic test_timeout();
      int prev;
      prev = tx_count;
      send_byte(8'hB0);
      gap(); send_byte(8'h00);
      gap(); send_byte(8'h04);
      wait_response("tmo", prev);
      total++; if (last_tx !== 8'h15) begin bad++; $display("FAIL tmo_tx: got %h want 15", last_tx); end
      total++; if (error !== 1'b1) begin bad++; $display("FAIL tmo_error: got %b want 1", error); end
      prev = tx_count;
      clear_log();
      payload = '{8'h10, 8'h20, 8'h30, 8'h40};
      send_byte(8'hB0);
      send_hdr(32'h0000_0400, 32'd4);
      send_payload();
      gap(); send_byte(8'hA0);
      wait_response("tmo_next", prev);
      total++; if (last_tx !== 8'h06) begin bad++; $display("FAIL tmo_next_tx: got %h want 06", last_tx); end
      total++; if (cpu_reset_hold !== 1'b0) begin bad++; $display("FAIL tmo_next_hold: got %b want 0", cpu_reset_hold); end
      total++;
      if (wr_addr.size() != 1) begin bad++; $display("FAIL tmo_next_nwrites: got %0d want 1", wr_addr.size()); end
      else begin
         total++;
         if ({wr_addr[0], wr_data[0], wr_be[0]} !== {26'h400, 32'h40302010, 4'hF}) begin
            bad++; $display("FAIL tmo_next_w0: got %h/%h/%h want 400/40302010/f", wr_addr[0], wr_data[0], wr_be[0]);
         end
      end
   endtask

   task automatic test_garbage();
      int prev;
      prev = tx_count;
      send_byte(8'h00);
      gap(); send_byte(8'hFF);
      gap(); send_byte(8'h15);
      gap();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL garb_busy: got %b want 0", busy); end
      total++; if (tx_count != prev) begin bad++; $display("FAIL garb_tx: pulses=%0d want %0d", tx_count, prev); end
      total++; if (cpu_reset_hold !== 1'b0) begin bad++; $display("FAIL garb_hold: got %b want 0", cpu_reset_hold); end
   endtask

   task automatic test_reset_mid();
      auto_ready = 1'b0;
      payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send_byte(8'hB0);
      send_hdr(32'h0000_0500, 32'd8);
      send_payload();
      total++; if (mem.mem_request !== 1'b1) begin bad++; $display("FAIL mid_pending: got %b want 1", mem.mem_request); end
      reset = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
      total++; if (cpu_reset_hold !== 1'b0) begin bad++; $display("FAIL mid_hold: got %b want 0", cpu_reset_hold); end
      total++; if (mem.mem_request !== 1'b0) begin bad++; $display("FAIL mid_req: got %b want 0", mem.mem_request); end
      total++;
      if ({mem.mem_address, mem.mem_wdata, mem.mem_byte_enable, tx_valid, tx_data, error} !== '0) begin
         bad++;
         $display("FAIL mid_outputs: addr=%h wdata=%h be=%h txv=%b txd=%h err=%b want all 0",
                  mem.mem_address, mem.mem_wdata, mem.mem_byte_enable, tx_valid, tx_data, error);
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      auto_ready = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_ack();
      test_nak();
      test_partial();
      test_overrun();
      test_timeout();
      test_garbage();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
